// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port byte-addressed data memory (A = MEM stage, B = DMA/debug loader).
// Optional address range checking is enabled by defining DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_BYTES    = 128,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_err_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              b_err_o,
  output logic              last_b_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT) + 1;

  logic              a_req_v, b_req_v, a_gnt, b_gnt, any_gnt, starved, bad;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              a_rvalid_q, b_rvalid_q, a_err_q, b_err_q, last_b_q;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  // Requests are masked while in reset so nothing is granted or issued to memory.
  always_comb begin
    a_req_v = a_req_i & rst_i;
    b_req_v = b_req_i & rst_i;
    starved = (wait_cnt_q >= CNT_W'(STARVE_LIMIT));
    b_gnt   = b_req_v & (~a_req_v | starved);
    a_gnt   = a_req_v & ~b_gnt;
    any_gnt = a_gnt | b_gnt;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (b_gnt) begin
      sel_we    = b_we_i;
      sel_addr  = b_addr_i;
      sel_wdata = b_wdata_i;
    end else if (a_gnt) begin
      sel_we    = a_we_i;
      sel_addr  = a_addr_i;
      sel_wdata = a_wdata_i;
    end
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  // Extra bit keeps addr+4 from wrapping near the top of the address space.
  always_comb begin
    bad = any_gnt &&
          ((sel_addr[1:0] != 2'b00) ||
           (({1'b0, sel_addr} + (ADDR_W+1)'(4)) > (ADDR_W+1)'(MEM_BYTES)));
  end
`else
  always_comb bad = 1'b0;
`endif

  always_comb begin
    mem_addr_o  = sel_addr;
    mem_wdata_o = sel_wdata;
    mem_read_o  = any_gnt & ~sel_we & ~bad;
    mem_write_o = any_gnt &  sel_we & ~bad;
  end

  // Saturating count of consecutive cycles B has been kept waiting.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!b_req_v || b_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < CNT_W'(STARVE_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Reads capture memory data, writes keep the old value, rejected accesses return zero.
  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_gnt && bad)         a_rdata_d = '0;
    else if (a_gnt && !sel_we) a_rdata_d = mem_rdata_i;
    if (b_gnt && bad)         b_rdata_d = '0;
    else if (b_gnt && !sel_we) b_rdata_d = mem_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      wait_cnt_q <= '0;
      last_b_q   <= 1'b0;
    end else begin
      a_rvalid_q <= a_gnt;
      b_rvalid_q <= b_gnt;
      a_err_q    <= a_gnt & bad;
      b_err_q    <= b_gnt & bad;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      wait_cnt_q <= wait_cnt_d;
      if (any_gnt) last_b_q <= b_gnt;
    end
  end

  assign a_gnt_o    = a_gnt;
  assign b_gnt_o    = b_gnt;
  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;
  assign a_err_o    = a_err_q;
  assign b_err_o    = b_err_q;
  assign last_b_o   = last_b_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a 128-byte behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, last_b;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [7:0] mem [128] = '{default: 8'h00};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err),
    .last_b_o(last_b),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] rd_word(int a);
    return {mem[(a+3)%128], mem[(a+2)%128], mem[(a+1)%128], mem[a%128]};
  endfunction

  always_comb mem_rdata = rd_word(int'(mem_addr[6:0]));

  always @(posedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 4; k++) mem[(int'(mem_addr[6:0]) + k) % 128] <= mem_wdata[8*k +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic        e_agnt, e_bgnt, e_mr, e_mw;
    logic [31:0] e_maddr, e_mwdata;
    logic        e_arv;
    logic [31:0] e_ard;
    logic        e_brv;
    logic [31:0] e_brd;
  } vec_t;

  function automatic vec_t mkv(
    logic ar, logic aw, logic [31:0] aa, logic [31:0] ad,
    logic br, logic bw, logic [31:0] ba, logic [31:0] bd,
    logic eag, logic ebg, logic emr, logic emw, logic [31:0] ema, logic [31:0] emd,
    logic earv, logic [31:0] eard, logic ebrv, logic [31:0] ebrd);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.e_agnt = eag; v.e_bgnt = ebg; v.e_mr = emr; v.e_mw = emw;
    v.e_maddr = ema; v.e_mwdata = emd;
    v.e_arv = earv; v.e_ard = eard; v.e_brv = ebrv; v.e_brd = ebrd;
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'h1111_1111;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;

    // Reset held two cycles with a pending A write: nothing granted or committed.
    @(negedge clk); #1;
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_last_b", 32'(last_b), 32'd0);
    chk("rst_mem_0x10", rd_word(32'h10), 32'd0);

    //            A: req we addr  wdata          B: req we addr  wdata          agnt bgnt mr mw maddr  mwdata         arv ard            brv brd
    vecs[0]  = mkv(1, 1, 32'h10, 32'hDEADBEEF,  0, 0, 32'h00, 32'h0,          1, 0, 0, 1, 32'h10, 32'hDEADBEEF,  1, 32'h0,         0, 32'h0);
    vecs[1]  = mkv(1, 0, 32'h10, 32'h5A5A5A5A,  0, 0, 32'h00, 32'h0,          1, 0, 1, 0, 32'h10, 32'h5A5A5A5A,  1, 32'hDEADBEEF,  0, 32'h0);
    vecs[2]  = mkv(0, 0, 32'h00, 32'h0,         0, 0, 32'h00, 32'h0,          0, 0, 0, 0, 32'h00, 32'h0,         0, 32'hDEADBEEF,  0, 32'h0);
    vecs[3]  = mkv(0, 0, 32'h00, 32'h0,         1, 1, 32'h20, 32'h12345678,   0, 1, 0, 1, 32'h20, 32'h12345678,  0, 32'hDEADBEEF,  1, 32'h0);
    vecs[4]  = mkv(0, 0, 32'h00, 32'h0,         1, 0, 32'h20, 32'h0,          0, 1, 1, 0, 32'h20, 32'h0,         0, 32'hDEADBEEF,  1, 32'h12345678);
    // Both request every cycle: A wins four times (wait_cnt 0..3), B wins on the fifth.
    vecs[5]  = mkv(1, 0, 32'h20, 32'h0,         1, 0, 32'h10, 32'h0,          1, 0, 1, 0, 32'h20, 32'h0,         1, 32'h12345678,  0, 32'h12345678);
    vecs[6]  = mkv(1, 0, 32'h10, 32'h0,         1, 0, 32'h10, 32'h0,          1, 0, 1, 0, 32'h10, 32'h0,         1, 32'hDEADBEEF,  0, 32'h12345678);
    vecs[7]  = mkv(1, 0, 32'h20, 32'h0,         1, 0, 32'h10, 32'h0,          1, 0, 1, 0, 32'h20, 32'h0,         1, 32'h12345678,  0, 32'h12345678);
    vecs[8]  = mkv(1, 1, 32'h24, 32'hCAFEF00D,  1, 0, 32'h10, 32'h0,          1, 0, 0, 1, 32'h24, 32'hCAFEF00D,  1, 32'h12345678,  0, 32'h12345678);
    vecs[9]  = mkv(1, 0, 32'h24, 32'h0,         1, 0, 32'h10, 32'h0,          0, 1, 1, 0, 32'h10, 32'h0,         0, 32'h12345678,  1, 32'hDEADBEEF);
    vecs[10] = mkv(1, 0, 32'h24, 32'h0,         1, 0, 32'h20, 32'h0,          1, 0, 1, 0, 32'h24, 32'h0,         1, 32'hCAFEF00D,  0, 32'hDEADBEEF);
    vecs[11] = mkv(0, 0, 32'h00, 32'h0,         1, 0, 32'h20, 32'h0,          0, 1, 1, 0, 32'h20, 32'h0,         0, 32'hCAFEF00D,  1, 32'h12345678);
    vecs[12] = mkv(0, 0, 32'h00, 32'h0,         0, 0, 32'h00, 32'h0,          0, 0, 0, 0, 32'h00, 32'h0,         0, 32'hCAFEF00D,  0, 32'h12345678);

    @(negedge clk);
    rst = 1'b1; a_req = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      #1;
      chk($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(vecs[i].e_agnt));
      chk($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(vecs[i].e_bgnt));
      chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].e_mr));
      chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].e_mw));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d_a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].e_arv));
      chk($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].e_ard);
      chk($sformatf("v%0d_b_rvalid", i), 32'(b_rvalid), 32'(vecs[i].e_brv));
      chk($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].e_brd);
      chk($sformatf("v%0d_a_err", i), 32'(a_err), 32'd0);
    end
    chk("last_b_after_b_win", 32'(last_b), 32'd1);
    chk("mem_0x24", rd_word(32'h24), 32'hCAFEF00D);

    // Reset in the cycle after an A read grant suppresses the completion.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
    @(posedge clk); #1;
    chk("pre_rst_a_rvalid", 32'(a_rvalid), 32'd1);
    @(negedge clk);
    rst = 1'b0; a_req = 1'b0;
    @(posedge clk); #1;
    chk("midrst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("midrst_a_rdata", a_rdata, 32'd0);
    chk("midrst_b_rdata", b_rdata, 32'd0);
    chk("midrst_last_b", 32'(last_b), 32'd0);

    // A write presented while reset is low must not commit.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'hAAAA5555;
    #1;
    chk("rstwr_a_gnt", 32'(a_gnt), 32'd0);
    chk("rstwr_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    chk("rstwr_mem_0x30", rd_word(32'h30), 32'd0);

    @(negedge clk);
    rst = 1'b1; a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
    @(posedge clk); #1;
    chk("postrst_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("postrst_a_rdata", a_rdata, 32'hDEADBEEF);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    // Out-of-range write is granted but never reaches memory.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h7E; a_wdata = 32'h99999999;
    #1;
    chk("rng_a_gnt", 32'(a_gnt), 32'd1);
    chk("rng_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    chk("rng_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("rng_a_err", 32'(a_err), 32'd1);
    chk("rng_a_rdata", a_rdata, 32'd0);
    chk("rng_mem_0x7c", rd_word(32'h7C), 32'd0);
`endif

    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    chk("idle_a_rvalid", 32'(a_rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
